// File: rtl/dmem_block_mover.sv
// dmem_block_mover: memmove/fill sequencer in front of a single-port data memory
//   Clk, Reset (async, active-low)
//   Start/Mode/SrcAddr/DstAddr/Len/FillData : transfer request, latched while idle
//   CoreAddr/CoreDataIn/CoreMemWrite        : core port, passed through while idle
//   MemDataOut (comb read) / MemAddr / MemDataIn / MemWrite : memory port
//   Busy/Stall : transfer running, Done : one-cycle completion pulse
module dmem_block_mover #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Mode,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Len,
    input  logic [W-1:0] FillData,
    input  logic [A-1:0] CoreAddr,
    input  logic [W-1:0] CoreDataIn,
    input  logic         CoreMemWrite,
    input  logic [W-1:0] MemDataOut,
    output logic [A-1:0] MemAddr,
    output logic [W-1:0] MemDataIn,
    output logic         MemWrite,
    output logic         Busy,
    output logic         Stall,
    output logic         Done
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
    state_t state_q, state_d;
    logic [A-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
    logic [W-1:0] hold_q, hold_d, fill_q, fill_d;
    logic mode_q, mode_d, desc_q, desc_d, busy_q, busy_d, done_q, done_d;
    logic dn;
    logic [A-1:0] step;
    always_comb begin
        state_d = state_q;
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        hold_d = hold_q;
        fill_d = fill_q;
        mode_d = mode_q;
        desc_d = desc_q;
        // copying towards higher addresses must run top-down to survive overlap
        dn = ~Mode && (DstAddr > SrcAddr);
        step = desc_q ? '1 : A'(1);
        case (state_q)
            IDLE: if (Start) begin
                if (Len == '0) begin
                    state_d = FIN;
                end else begin
                    mode_d = Mode;
                    desc_d = dn;
                    src_d = dn ? SrcAddr + Len - A'(1) : SrcAddr;
                    dst_d = dn ? DstAddr + Len - A'(1) : DstAddr;
                    cnt_d = Len;
                    fill_d = FillData;
                    state_d = Mode ? WR : RD;
                end
            end
            RD: begin
                hold_d = MemDataOut;
                state_d = WR;
            end
            WR: begin
                cnt_d = cnt_q - A'(1);
                src_d = src_q + step;
                dst_d = dst_q + step;
                state_d = (cnt_q == A'(1)) ? FIN : (mode_q ? WR : RD);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RD) || (state_d == WR);
        done_d = state_d == FIN;
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            cnt_q <= '0;
            hold_q <= '0;
            fill_q <= '0;
            mode_q <= 1'b0;
            desc_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
            hold_q <= hold_d;
            fill_q <= fill_d;
            mode_q <= mode_d;
            desc_q <= desc_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    always_comb begin
        MemAddr = (state_q == RD) ? src_q : (state_q == WR) ? dst_q : CoreAddr;
        MemDataIn = (state_q == WR) ? (mode_q ? fill_q : hold_q) : CoreDataIn;
        MemWrite = (state_q == WR) ? 1'b1 : (state_q == RD) ? 1'b0 : CoreMemWrite;
        Busy = busy_q;
        Stall = busy_q;
        Done = done_q;
    end
endmodule

// File: tb/tb_dmem_block_mover.sv
// tb_dmem_block_mover: directed bench with a memmove/fill reference model
module tb_dmem_block_mover;
    logic Clk = 0, Reset = 0, Start = 0, Mode = 0, CoreMemWrite = 0;
    logic [7:0] SrcAddr = 0, DstAddr = 0, Len = 0, FillData = 0, CoreAddr = 0, CoreDataIn = 0;
    logic [7:0] MemDataOut, MemAddr, MemDataIn;
    logic MemWrite, Busy, Stall, Done;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int n_chk = 0, n_fail = 0;
    int bl = 0;
    logic dn = 0, mon = 0;

    dmem_block_mover #(.W(8), .A(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .SrcAddr(SrcAddr),
        .DstAddr(DstAddr), .Len(Len), .FillData(FillData), .CoreAddr(CoreAddr),
        .CoreDataIn(CoreDataIn), .CoreMemWrite(CoreMemWrite), .MemDataOut(MemDataOut),
        .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemWrite(MemWrite),
        .Busy(Busy), .Stall(Stall), .Done(Done)
    );

    always #5 Clk = ~Clk;
    assign MemDataOut = mem[MemAddr];
    always @(posedge Clk) if (MemWrite) mem[MemAddr] = MemDataIn;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // timing model: a transfer occupies the port for Len (fill) or 2*Len (copy)
    // cycles, then Done for one cycle; Start is only honoured when neither is active
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bl <= 0;
            dn <= 0;
        end else if (bl > 0) begin
            bl <= bl - 1;
            dn <= (bl == 1);
        end else if (dn) begin
            dn <= 0;
        end else if (Start) begin
            bl <= (Len == 0) ? 0 : (Mode ? int'(Len) : 2 * int'(Len));
            dn <= (Len == 0);
        end
    end

    always @(negedge Clk) if (mon && Reset) begin
        chk("busy", Busy, bl > 0);
        chk("stall", Stall, bl > 0);
        chk("done", Done, dn);
        if (bl == 0) begin
            chk("pass_addr", MemAddr, CoreAddr);
            chk("pass_wen", MemWrite, CoreMemWrite);
            chk("pass_data", MemDataIn, CoreDataIn);
        end
    end

    task automatic poke(input int a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    // memmove semantics: the source is captured before any destination byte lands;
    // only the first k bytes are committed (k < len models an aborted transfer)
    task automatic model_move(input logic m, input int src, input int dst, input int len,
                              input logic [7:0] fd, input int k);
        logic [7:0] tmp [256];
        for (int i = 0; i < len; i++) tmp[i] = m ? fd : ref_mem[(src + i) % 256];
        for (int i = 0; i < k; i++) ref_mem[(dst + i) % 256] = tmp[i];
    endtask

    task automatic mem_cmp(input string nm);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(nm, bad, 0);
    endtask

    // issue a request; intf drives core traffic and a second Start mid-transfer;
    // abort_at > 0 pulls Reset in that cycle instead of waiting for Done
    task automatic xfer(input string nm, input logic m, input int src, input int dst,
                        input int len, input logic [7:0] fd, input bit intf, input int abort_at,
                        output int done_cyc, output int busy_cyc);
        int c = 0;
        done_cyc = 0;
        busy_cyc = 0;
        @(negedge Clk);
        Start = 1; Mode = m; SrcAddr = 8'(src); DstAddr = 8'(dst); Len = 8'(len); FillData = fd;
        @(posedge Clk);
        #1 Start = 0;
        while (c < 600) begin
            @(negedge Clk);
            c++;
            if (Busy) busy_cyc++;
            if (Done) begin done_cyc = c; break; end
            if (intf && c == 2) begin
                CoreMemWrite = 1; CoreAddr = 8'd5; CoreDataIn = 8'hFF; Start = 1;
            end
            if (intf && c == 3) Start = 0;
            if (intf && c == 4) CoreMemWrite = 0;
            if (abort_at > 0 && c == abort_at) begin
                #2 Reset = 0;
                #1;
                chk({nm, "_rst_busy"}, Busy, 0);
                chk({nm, "_rst_done"}, Done, 0);
                chk({nm, "_rst_addr"}, MemAddr, CoreAddr);
                chk({nm, "_rst_wen"}, MemWrite, CoreMemWrite);
                @(negedge Clk);
                Reset = 1;
                break;
            end
        end
        if (abort_at == 0 && done_cyc == 0) chk({nm, "_timeout"}, 0, 1);
        model_move(m, src, dst, len, fd, abort_at > 0 ? abort_at - 1 : (len == 0 ? 0 : len));
        mem_cmp({nm, "_mem"});
    endtask

    initial begin
        int dc, bc;
        for (int i = 0; i < 256; i++) poke(i, 8'(~i));
        repeat (3) @(negedge Clk);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_stall", Stall, 0);
        Reset = 1;
        mon = 1;

        xfer("fill", 1, 0, 64, 4, 8'hA5, 0, 0, dc, bc);
        chk("fill_done_cyc", dc, 5);
        chk("fill_busy_cyc", bc, 4);
        chk("fill_m64", mem[64], 8'hA5);
        chk("fill_m67", mem[67], 8'hA5);
        chk("fill_m63", mem[63], 8'hC0);
        chk("fill_m68", mem[68], 8'hBB);

        for (int i = 0; i < 4; i++) poke(10 + i, 8'(i + 1));
        xfer("copy", 0, 10, 100, 4, 0, 0, 0, dc, bc);
        chk("copy_done_cyc", dc, 9);
        chk("copy_busy_cyc", bc, 8);
        chk("copy_m100", mem[100], 8'h01);
        chk("copy_m103", mem[103], 8'h04);

        for (int i = 0; i < 4; i++) poke(20 + i, 8'(i + 1));
        xfer("ovl_up", 0, 20, 22, 4, 0, 0, 0, dc, bc);
        chk("ovl_up_m22", mem[22], 8'h01);
        chk("ovl_up_m23", mem[23], 8'h02);
        chk("ovl_up_m25", mem[25], 8'h04);
        xfer("ovl_dn", 0, 22, 20, 4, 0, 0, 0, dc, bc);
        chk("ovl_dn_m20", mem[20], 8'h01);
        chk("ovl_dn_m23", mem[23], 8'h04);

        xfer("len0", 1, 0, 30, 0, 8'h11, 0, 0, dc, bc);
        chk("len0_done_cyc", dc, 1);
        chk("len0_busy_cyc", bc, 0);

        xfer("core", 0, 10, 40, 4, 0, 1, 0, dc, bc);
        chk("core_done_cyc", dc, 9);
        chk("core_m5_kept", mem[5], 8'hFA);
        @(negedge Clk);
        CoreAddr = 8'd5; CoreDataIn = 8'hFF; CoreMemWrite = 1;
        @(negedge Clk);
        CoreMemWrite = 0;
        ref_mem[5] = 8'hFF;
        chk("core_m5_wr", mem[5], 8'hFF);
        mem_cmp("core_after_mem");

        xfer("wrap", 1, 0, 254, 4, 8'h3C, 0, 0, dc, bc);
        chk("wrap_m254", mem[254], 8'h3C);
        chk("wrap_m255", mem[255], 8'h3C);
        chk("wrap_m0", mem[0], 8'h3C);
        chk("wrap_m1", mem[1], 8'h3C);
        chk("wrap_m2", mem[2], 8'hFD);

        xfer("abort", 1, 0, 128, 4, 8'h77, 0, 3, dc, bc);
        chk("abort_m129", mem[129], 8'h77);
        chk("abort_m130", mem[130], 8'h7D);

        xfer("post_rst", 1, 0, 200, 2, 8'h42, 0, 0, dc, bc);
        chk("post_rst_done_cyc", dc, 3);

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
